// File: rtl/spart_rx_param.sv
// Parametrised SPART serial receiver.
// rx is synchronised, then oversampled on brg_en. Each bit is decided by a
// 3-sample majority vote taken around mid-bit. Completed frames go into a
// small receive FIFO that the bus side drains with rd. Framing, parity and
// overrun errors are held in sticky flags until err_clr.
// dbg_state exposes the FSM state for observation.
module spart_rx_param #(
  parameter int DATA_W     = 8,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        rx,
  input  logic                        brg_en,
  input  logic                        parity_en,
  input  logic                        parity_odd,
  input  logic                        two_stop,
  input  logic                        rd,
  input  logic                        err_clr,
  output logic [DATA_W-1:0]           dout,
  output logic                        rda,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        framing_err,
  output logic                        parity_err,
  output logic                        overrun,
  output logic [2:0]                  dbg_state
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(OVS);
  localparam int BW = $clog2(DATA_W);

  localparam logic [TW-1:0] T_S0   = TW'(OVS/2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVS/2);
  localparam logic [TW-1:0] T_V    = TW'(OVS/2 + 1);
  localparam logic [TW-1:0] T_END  = TW'(OVS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam logic [CW-1:0] C_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH
  } state_t;

  state_t state, state_n;

  logic              rx_meta, rx_s;
  logic [TW-1:0]     tc;
  logic [BW-1:0]     bit_idx;
  logic [DATA_W-1:0] sh;
  logic              s0, s1;
  logic              cfg_pe, cfg_odd, cfg_two;
  logic              f_ferr, f_perr;
  logic              fin, frame_done;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;

  logic vote, tick_v, tick_end, start_det;
  logic full, push, pop, ovr_set;

  assign vote      = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
  assign tick_v    = brg_en && (tc == T_V);
  assign tick_end  = brg_en && (tc == T_END);
  assign start_det = (state == IDLE) && brg_en && !rx_s;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; frame_done marks the vote tick of the last stop bit.
  always_comb begin
    state_n    = state;
    frame_done = 1'b0;
    case (state)
      IDLE:      if (start_det) state_n = START;
      START: begin
        if (tick_v && vote) state_n = IDLE;
        else if (tick_end)  state_n = DATA;
      end
      DATA:      if (tick_end && bit_idx == B_LAST) state_n = cfg_pe ? PARITY : STOP1;
      PARITY:    if (tick_end) state_n = STOP1;
      STOP1: begin
        if (fin)                      state_n = f_ferr ? WAIT_HIGH : IDLE;
        else if (!cfg_two && tick_v)  frame_done = 1'b1;
        else if (cfg_two && tick_end) state_n = STOP2;
      end
      STOP2: begin
        if (fin)         state_n = f_ferr ? WAIT_HIGH : IDLE;
        else if (tick_v) frame_done = 1'b1;
      end
      WAIT_HIGH: if (brg_en && rx_s) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // Tick counter, vote samples, shift register and per-frame error capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tc      <= '0;
      bit_idx <= '0;
      sh      <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      cfg_pe  <= 1'b0;
      cfg_odd <= 1'b0;
      cfg_two <= 1'b0;
      f_ferr  <= 1'b0;
      f_perr  <= 1'b0;
      fin     <= 1'b0;
    end else begin
      fin <= frame_done;
      if (state == IDLE) begin
        tc <= '0;
        if (start_det) begin
          cfg_pe  <= parity_en;
          cfg_odd <= parity_odd;
          cfg_two <= two_stop;
          f_ferr  <= 1'b0;
          f_perr  <= 1'b0;
          bit_idx <= '0;
        end
      end else if (brg_en) begin
        tc <= (tc == T_END) ? '0 : tc + 1'b1;
        if (tc == T_S0) s0 <= rx_s;
        if (tc == T_S1) s1 <= rx_s;
        if (tc == T_V) begin
          case (state)
            DATA:        sh <= {vote, sh[DATA_W-1:1]};
            PARITY:      if ((^sh ^ vote) != cfg_odd) f_perr <= 1'b1;
            STOP1, STOP2: if (!vote) f_ferr <= 1'b1;
            default:     ;
          endcase
        end
        if (tc == T_END && state == DATA) bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  assign full    = (count == C_FULL);
  assign rda     = (count != '0);
  assign pop     = rd && rda;
  assign push    = fin && (!full || rd);
  assign ovr_set = fin && full && !rd;

  // FIFO storage; contents need no reset because dout is gated by rda.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sh;
  end

  // FIFO pointers, occupancy and sticky error flags (new error beats err_clr).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      framing_err <= 1'b0;
      parity_err  <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      framing_err <= (framing_err & ~err_clr) | (fin & f_ferr);
      parity_err  <= (parity_err  & ~err_clr) | (fin & f_perr);
      overrun     <= (overrun     & ~err_clr) | ovr_set;
    end
  end

  assign dout       = rda ? mem[rd_ptr] : '0;
  assign fifo_count = count;
  assign dbg_state  = state;

endmodule

// File: tb/tb_spart_rx_param.sv
// Directed bench for spart_rx_param (DATA_W=8, OVS=16, FIFO_DEPTH=4).
// Frames are driven one bit per 16 brg_en ticks; expected FIFO data is queued
// when a frame is sent and a negedge monitor pops and compares on each read.
module tb_spart_rx_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       brg_en = 1'b0;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
  logic       rd = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] dout;
  logic       rda;
  logic [2:0] fifo_count;
  logic       framing_err, parity_err, overrun;
  logic [2:0] dbg_state;

  logic [7:0] exp_q[$];
  int         checks = 0;
  int         failures = 0;
  logic       saw_wh = 1'b0;

  spart_rx_param #(.DATA_W(8), .OVS(16), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .brg_en(brg_en),
    .parity_en(parity_en), .parity_odd(parity_odd), .two_stop(two_stop),
    .rd(rd), .err_clr(err_clr), .dout(dout), .rda(rda),
    .fifo_count(fifo_count), .framing_err(framing_err),
    .parity_err(parity_err), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock and oversample tick (one pulse every 4 clk)
  always #5 clk = ~clk;

  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk);
      cnt = (cnt == 3) ? 0 : cnt + 1;
      brg_en = (cnt == 3);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: a read of a non-empty FIFO must present the queue head
  always @(negedge clk) begin
    if (rd && rda) begin
      if (exp_q.size() == 0) check("dout_unexpected", int'(dout), -1);
      else check("dout", int'(dout), int'(exp_q.pop_front()));
    end
    if (dbg_state == 3'd6) saw_wh = 1'b1;
  end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      do @(posedge clk); while (!brg_en);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit par_on, input logic par_bit,
                            input int nstop, input logic last_stop, input bit rd_at_end);
    rx = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_ticks(16);
    end
    if (par_on) begin
      rx = par_bit;
      wait_ticks(16);
    end
    for (int s = 0; s < nstop; s++) begin
      rx = (s == nstop - 1) ? last_stop : 1'b1;
      if (s == nstop - 1 && rd_at_end) begin
        // the last stop is voted on the 10th tick; the push follows one clk later
        wait_ticks(10);
        rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
        wait_ticks(6);
      end else begin
        wait_ticks(16);
      end
    end
    rx = 1'b1;
  endtask

  task automatic do_read();
    @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 err_clr = 1'b1;
    @(posedge clk);
    #1 err_clr = 1'b0;
  endtask

  task automatic check_flags(input string tag, input int f, input int p, input int o);
    check({tag, "_framing"}, int'(framing_err), f);
    check({tag, "_parity"},  int'(parity_err),  p);
    check({tag, "_overrun"}, int'(overrun),     o);
  endtask

  initial begin
    // reset state
    #23;
    check("rst_rda", int'(rda), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_state", int'(dbg_state), 0);
    check_flags("rst", 0, 0, 0);
    rst_n = 1'b1;
    wait_ticks(4);

    // 8N1 back-to-back frames
    exp_q.push_back(8'hA5); send_frame(8'hA5, 0, 1'b0, 1, 1'b1, 0);
    exp_q.push_back(8'h3C); send_frame(8'h3C, 0, 1'b0, 1, 1'b1, 0);
    wait_ticks(2);
    check("8n1_count2", int'(fifo_count), 2);
    check("8n1_rda", int'(rda), 1);
    check_flags("8n1", 0, 0, 0);
    do_read();
    check("8n1_count1", int'(fifo_count), 1);
    do_read();
    check("8n1_count0", int'(fifo_count), 0);
    do_read();
    check("empty_rd_count", int'(fifo_count), 0);

    // 8E1 with wrong parity bit, then 8O1 with correct parity
    parity_en = 1'b1; parity_odd = 1'b0;
    exp_q.push_back(8'h07); send_frame(8'h07, 1, 1'b0, 1, 1'b1, 0);
    wait_ticks(2);
    check_flags("8e1_bad", 0, 1, 0);
    do_read();
    pulse_clr();
    check("8e1_clr_parity", int'(parity_err), 0);
    parity_odd = 1'b1;
    exp_q.push_back(8'h07); send_frame(8'h07, 1, 1'b0, 1, 1'b1, 0);
    wait_ticks(2);
    check_flags("8o1_good", 0, 0, 0);
    do_read();

    // 8N2 with second stop low, recovery through WAIT_HIGH
    parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
    saw_wh = 1'b0;
    exp_q.push_back(8'h33); send_frame(8'h33, 0, 1'b0, 2, 1'b0, 0);
    wait_ticks(4);
    check("8n2_saw_wait_high", int'(saw_wh), 1);
    exp_q.push_back(8'h55); send_frame(8'h55, 0, 1'b0, 2, 1'b1, 0);
    wait_ticks(2);
    check("8n2_count", int'(fifo_count), 2);
    check_flags("8n2", 1, 0, 0);
    do_read();
    do_read();
    pulse_clr();
    check("8n2_clr_framing", int'(framing_err), 0);
    two_stop = 1'b0;

    // glitch: low for only 4 ticks
    rx = 1'b0; wait_ticks(4);
    rx = 1'b1; wait_ticks(24);
    check("glitch_count", int'(fifo_count), 0);
    check("glitch_state", int'(dbg_state), 0);
    check_flags("glitch", 0, 0, 0);

    // overrun: five frames, no reads
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_frame(8'(k), 0, 1'b0, 1, 1'b1, 0);
    end
    wait_ticks(2);
    check("ovr_count", int'(fifo_count), 4);
    check_flags("ovr", 0, 0, 1);
    repeat (4) do_read();
    check("ovr_drained", int'(fifo_count), 0);
    pulse_clr();
    check("ovr_clr", int'(overrun), 0);

    // full FIFO with rd in the completion cycle: pop and push together
    for (int k = 0; k < 5; k++) begin
      exp_q.push_back(8'h11 + 8'(k));
      send_frame(8'h11 + 8'(k), 0, 1'b0, 1, 1'b1, k == 4);
    end
    wait_ticks(2);
    check("rdfull_count", int'(fifo_count), 4);
    check("rdfull_overrun", int'(overrun), 0);
    repeat (4) do_read();

    // reset during DATA bit 3 flushes the FIFO
    exp_q.push_back(8'h42); send_frame(8'h42, 0, 1'b0, 1, 1'b1, 0);
    wait_ticks(2);
    check("prerst_count", int'(fifo_count), 1);
    rx = 1'b0; wait_ticks(16);
    for (int i = 0; i < 3; i++) begin
      rx = 1'b0; wait_ticks(16);
    end
    rx = 1'b0; wait_ticks(5);
    rst_n = 1'b0;
    #2;
    check("midrst_rda", int'(rda), 0);
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_dout", int'(dout), 0);
    check("midrst_state", int'(dbg_state), 0);
    exp_q.delete();
    #20 rx = 1'b1;
    #20 rst_n = 1'b1;
    wait_ticks(4);
    exp_q.push_back(8'hFF); send_frame(8'hFF, 0, 1'b0, 1, 1'b1, 0);
    wait_ticks(2);
    check("postrst_count", int'(fifo_count), 1);
    check_flags("postrst", 0, 0, 0);
    do_read();

    wait_ticks(2);
    check("exp_q_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spart_rx_param.md
Name: spart_rx_param

Overview:
- Parametrised next-generation SPART serial receiver.
- Oversamples RX on the baud-rate-generator enable and takes a 3-sample majority vote per bit.
- Supports configurable data width, optional even/odd parity and 1 or 2 stop bits, with error detection.
- Buffers completed frames in a small receive FIFO that the bus interface drains with a read strobe, replacing the single-entry RDA handshake.

Parameters:
DATA_W, 8, data bits per frame (5..9), LSB first on the line
OVS, 16, brg_en ticks per bit period (even, >=8)
FIFO_DEPTH, 4, receive FIFO entries (power of 2, >=2)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
rx  in  1  serial input, asynchronous to clk, idle high
brg_en  in  1  oversample tick, one-cycle pulse, OVS per bit period
parity_en  in  1  1 = frame carries a parity bit
parity_odd  in  1  1 = odd parity, 0 = even parity
two_stop  in  1  1 = two stop bits expected
rd  in  1  pop strobe; removes the FIFO head entry
err_clr  in  1  clears all sticky error flags
dout  out  DATA_W  FIFO head entry, combinational, valid while rda=1
rda  out  1  FIFO not empty
fifo_count  out  $clog2(FIFO_DEPTH)+1  number of occupied entries
framing_err  out  1  sticky: a stop bit was voted 0
parity_err  out  1  sticky: parity mismatch
overrun  out  1  sticky: a frame completed while the FIFO was full

Behaviour:
- Reset (async, rst_n=0):
  - FSM goes to IDLE; counters, shift register and FIFO pointers clear.
  - Synchronizer flops are set to 1.
  - Outputs: rda=0, fifo_count=0, all error flags 0, dout=0.
  - Reset mid-frame discards the partial frame and flushes the FIFO.
- Input sync: rx passes through 2 flops to give rx_s. All logic uses rx_s only.
- Tick counter tc:
  - Advances only on brg_en, counting 0..OVS-1, and wraps.
  - Bit sample = majority of rx_s captured at tc = OVS/2-1, OVS/2, OVS/2+1.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2, WAIT_HIGH.
- IDLE:
  - On brg_en with rx_s=0, go to START with tc=0.
  - Latch parity_en, parity_odd and two_stop; mid-frame config changes are ignored.
- START:
  - Vote 1 is a false start: return to IDLE, no flag.
  - Vote 0: at tc=OVS-1 go to DATA, bit index=0.
- DATA:
  - Each vote shifts in at the MSB and shifts the register right.
  - After DATA_W bits, go to PARITY if parity_en, else STOP1.
- PARITY: the error condition is (XOR of data ^ parity bit) != parity_odd.
- STOP1:
  - Vote 0 sets the frame framing error.
  - If two_stop, continue to STOP2, which has identical checks.
- Frame completion:
  - Occurs at the vote tick of the last stop bit, which is mid-bit. This allows back-to-back frames.
  - On the next clk: push data, OR the frame errors into the sticky flags, then go to IDLE.
  - If any stop vote was 0 (break or line low), go to WAIT_HIGH instead. WAIT_HIGH returns to IDLE only after a brg_en with rx_s=1.
- Errored frames are still pushed.
- FIFO:
  - Push when not full, or when full with rd in the same cycle. In that case pop and push both happen and the count is unchanged.
  - Push when full without rd: drop the frame, set overrun, leave FIFO contents untouched.
  - rd when empty is ignored, and the count never underflows.
  - dout and rda update the cycle after a push or pop.
- Sticky flags:
  - err_clr clears them.
  - If err_clr and a new error occur in the same cycle, the new error wins (flag = 1).
- Latency: rda rises 2 clk after the brg_en that samples the last stop bit.

Test Plan:
- 8N1, OVS=16: send 0xA5 then 0x3C back-to-back → dout=0xA5, rd, dout=0x3C; fifo_count 2→1→0; no error flags.
- 8E1: send 0x07 with parity bit 0 (wrong; even parity requires 1) → dout=0x07 pushed, parity_err=1; err_clr → parity_err=0.
- 8N2: second stop bit driven 0 → framing_err=1, FSM passes through WAIT_HIGH; a following frame 0x55 is received correctly.
- Glitch: rx low for 4 ticks only → false start, fifo_count stays 0, no flags.
- Overrun, FIFO_DEPTH=4: send 5 frames 0x01..0x05 without rd → fifo_count=4, overrun=1, pops yield 0x01..0x04. Repeat with rd asserted in the cycle the 5th frame completes → count stays 4, no overrun.
- Assert rst_n=0 during DATA bit 3 → all outputs return to reset values immediately; the next full frame 0xFF is received intact.
